// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner:
// segment patterns (gfedcba, active-high) and the scan FSM encoding.
package seg_pkg;

   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   localparam logic [0:0] ST_SHOW  = 1'b0;
   localparam logic [0:0] ST_GUARD = 1'b1;

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-dwell prescaler: counts 0..CLK_DIV-1 and wraps, pulsing tick on the
// last count so the scan FSM sees exactly one tick per CLK_DIV cycles.
module seg_tick_gen #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == TC);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit BCD display scanner with a one-cycle blanking guard between
// digits, frame-aligned value commits and optional leading-zero blanking.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_SHOW  | drive digit idx until the prescaler ticks
//   ST_GUARD | one cycle with all digits off, then advance idx
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   output logic        wr_rdy,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [3:0]  dig_en
);

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      case (code)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

   // Digit 0 is never blanked so an all-zero value still shows "0".
   function automatic logic lz_blank(input logic [15:0] disp, input logic [1:0] idx,
                                     input logic en);
      logic zero;
      case (idx)
         2'd1:    zero = (disp[15:4] == 12'h000);
         2'd2:    zero = (disp[15:8] == 8'h00);
         2'd3:    zero = (disp[15:12] == 4'h0);
         default: zero = 1'b0;
      endcase
      return en & zero;
   endfunction

   logic        tick;
   logic [0:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        pending_q, pending_d;
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] disp_q, disp_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  dig_en_q, dig_en_d;
   logic [3:0]  digit;

   seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign wr_rdy = ~pending_q;
   assign seg    = seg_q;
   assign dig_en = dig_en_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;

      case (state_q)
         ST_SHOW: begin
            if (tick) begin
               state_d = ST_GUARD;
               // Commit only at the end of digit 3 so a frame never mixes values.
               if (idx_q == 2'd3 && pending_q) begin
                  disp_d    = shadow_q;
                  pending_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_SHOW;
            idx_d   = idx_q + 2'd1;
         end
      endcase

      if (wr_en && wr_rdy) begin
         shadow_d  = wr_data;
         pending_d = 1'b1;
      end

      digit = disp_q[{idx_q, 2'b00} +: 4];
      if (state_q == ST_SHOW) begin
         dig_en_d = 4'b0001 << idx_q;
         seg_d    = lz_blank(disp_q, idx_q, blank_lz) ? SEG_OFF : seg_decode(digit);
      end else begin
         dig_en_d = 4'b0000;
         seg_d    = SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_SHOW;
         idx_q     <= 2'd0;
         pending_q <= 1'b0;
         shadow_q  <= 16'h0000;
         disp_q    <= 16'h0000;
         seg_q     <= SEG_OFF;
         dig_en_q  <= 4'b0000;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         seg_q     <= seg_d;
         dig_en_q  <= dig_en_d;
      end
   end

endmodule
